// File: rtl/rodata_loader.sv
// rodata_loader: framed byte-stream loader writing a payload into read-only data memory
package cotm32_pkg;
  localparam int XLEN = 32;
  localparam int unsigned ROM_MEM_SIZE = 32'h0000_1000;
  localparam int unsigned ROM_MEM_START = 32'h0000_0000;
endpackage

module rodata_loader #(
  parameter int unsigned MEM_SIZE = cotm32_pkg::ROM_MEM_SIZE,
  parameter int unsigned MEM_BASE = cotm32_pkg::ROM_MEM_START
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_rx_valid,
  input  logic [7:0]                   i_rx_data,
  output logic                         o_rx_ready,
  output logic                         o_we,
  output logic [cotm32_pkg::XLEN-1:0]  o_waddr,
  output logic [7:0]                   o_wdata,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err,
  output logic [1:0]                   o_err_code
);
  localparam int XLEN = cotm32_pkg::XLEN;
  typedef enum logic [2:0] {IDLE, OFF, LEN, CHECK, DATA, CSUM, FIN} state_t;
  state_t r_state, w_next;
  logic [31:0] r_off, r_len, r_rem;
  logic [XLEN-1:0] r_ptr, r_waddr;
  logic [7:0] r_wdata, r_sum;
  logic [1:0] r_cnt, r_err_code;
  logic r_we, w_xfer, w_range_bad;
  logic [32:0] w_end;
  always_comb begin
    o_rx_ready = ~i_rst & (r_state != CHECK) & (r_state != FIN);
    w_xfer = i_rx_valid & o_rx_ready;
    w_end = {1'b0, r_off} + {1'b0, r_len};
    w_range_bad = w_end > 33'(MEM_SIZE);
    o_busy = r_state != IDLE;
    o_done = (r_state == FIN) && (r_err_code == 2'd0);
    o_err = (r_state == FIN) && (r_err_code != 2'd0);
    o_we = r_we;
    o_waddr = r_waddr;
    o_wdata = r_wdata;
    o_err_code = r_err_code;
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (w_xfer && i_rx_data == 8'hA5) ? OFF : IDLE;
      OFF:     w_next = (w_xfer && r_cnt == 2'd3) ? LEN : OFF;
      LEN:     w_next = (w_xfer && r_cnt == 2'd3) ? CHECK : LEN;
      CHECK:   w_next = w_range_bad ? FIN : (r_len == 32'd0 ? CSUM : DATA);
      DATA:    w_next = (w_xfer && r_rem == 32'd1) ? CSUM : DATA;
      CSUM:    w_next = w_xfer ? FIN : CSUM;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_off <= '0;
      r_len <= '0;
      r_rem <= '0;
      r_ptr <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_sum <= '0;
      r_cnt <= '0;
      r_err_code <= '0;
      r_we <= 1'b0;
    end else begin
      r_state <= w_next;
      r_we <= 1'b0;
      if (w_xfer) begin
        case (r_state)
          IDLE: if (i_rx_data == 8'hA5) begin
            r_err_code <= 2'd0;
            r_sum <= '0;
            r_cnt <= '0;
          end
          OFF: begin
            r_off <= {i_rx_data, r_off[31:8]};
            r_cnt <= r_cnt + 2'd1;
          end
          LEN: begin
            r_len <= {i_rx_data, r_len[31:8]};
            r_cnt <= r_cnt + 2'd1;
          end
          DATA: begin
            r_we <= 1'b1;
            r_waddr <= r_ptr;
            r_wdata <= i_rx_data;
            r_ptr <= r_ptr + 1'b1;
            r_rem <= r_rem - 32'd1;
            r_sum <= r_sum + i_rx_data;
          end
          CSUM: r_err_code <= (i_rx_data == r_sum) ? 2'd0 : 2'd2;
          default: ;
        endcase
      end
      if (r_state == CHECK) begin
        r_ptr <= XLEN'(MEM_BASE) + XLEN'(r_off);
        r_rem <= r_len;
        if (w_range_bad) r_err_code <= 2'd1;
      end
    end
  end
endmodule
